pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use detection, branch/jump flush and data-memory stall FSM.
// Optional macro HAZARD_PERF_CNT_EN adds the saturating stall-cycle counter output stall_cnt_o.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       IDEX_MemRead_i,
    input  logic [4:0] IDEX_Rt_i,
    input  logic [4:0] IFID_Rs_i,
    input  logic [4:0] IFID_Rt_i,
    input  logic       Branch_i,
    input  logic       Jump_i,
    input  logic       EXMEM_MemRead_i,
    input  logic       EXMEM_MemWrite_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       PCWrite_o,
    output logic       IFIDWrite_o,
    output logic       IDEXBubble_o,
    output logic       IFFlush_o,
    output logic       PipeStall_o,
    output logic       mem_timeout_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0] stall_cnt_o,
`endif
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [4:0] TIMEOUT_LIMIT = 5'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_stateNext;
    logic [3:0] r_waitCnt;
    logic [3:0] w_waitCntNext;
    logic [4:0] w_waitInc;
    logic       r_memTimeout;
    logic       w_memAccess;
    logic       w_stall;
    logic       w_loadUse;

    assign w_memAccess = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    assign w_waitInc   = {1'b0, r_waitCnt} + 5'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= RUN;
            r_waitCnt    <= 4'd0;
            r_memTimeout <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitCntNext;
            if (w_stateNext == ERR)
                r_memTimeout <= 1'b1;
        end
    end

    // An ack arriving on the timeout cycle still completes the access.
    always_comb begin
        w_stateNext   = r_state;
        w_waitCntNext = 4'd0;
        w_stall       = 1'b0;
        mem_req_o     = 1'b0;
        case (r_state)
            RUN: begin
                if (w_memAccess) begin
                    w_stall     = 1'b1;
                    w_stateNext = REQ;
                end
            end
            REQ: begin
                mem_req_o     = 1'b1;
                w_stall       = 1'b1;
                w_waitCntNext = w_waitInc[3:0];
                if (mem_ack_i)
                    w_stateNext = DONE;
                else if (w_waitInc >= TIMEOUT_LIMIT)
                    w_stateNext = ERR;
            end
            DONE: begin
                w_stateNext = RUN;
            end
            ERR: begin
                w_stall = 1'b1;
            end
            default: begin
                w_stateNext = RUN;
            end
        endcase
        if (rst_i) begin
            mem_req_o = 1'b0;
            w_stall   = 1'b0;
        end
    end

    assign w_loadUse = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                       ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

    // Priority: memory stall, then load-use bubble, then control-flow flush.
    always_comb begin
        PCWrite_o    = 1'b0;
        IFIDWrite_o  = 1'b0;
        IDEXBubble_o = 1'b0;
        IFFlush_o    = 1'b0;
        if (!rst_i && !w_stall) begin
            if (w_loadUse) begin
                IDEXBubble_o = 1'b1;
            end else begin
                PCWrite_o   = 1'b1;
                IFIDWrite_o = 1'b1;
                IFFlush_o   = Branch_i | Jump_i;
            end
        end
    end

    assign PipeStall_o   = w_stall;
    assign mem_timeout_o = r_memTimeout;
    assign state_o       = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stallCnt;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_stallCnt <= 16'd0;
        else if (!PCWrite_o && (r_stallCnt != 16'hFFFF))
            r_stallCnt <= r_stallCnt + 16'd1;
    end

    assign stall_cnt_o = r_stallCnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (hazards, flush, memory FSM, timeout, reset).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       idexMemRead;
    logic [4:0] idexRt;
    logic [4:0] ifidRs;
    logic [4:0] ifidRt;
    logic       branch;
    logic       jump;
    logic       exmemMemRead;
    logic       exmemMemWrite;
    logic       memAck;
    logic       memReq;
    logic       pcWrite;
    logic       ifidWrite;
    logic       idexBubble;
    logic       ifFlush;
    logic       pipeStall;
    logic       memTimeout;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stallCnt;
`endif

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .IDEX_MemRead_i   (idexMemRead),
        .IDEX_Rt_i        (idexRt),
        .IFID_Rs_i        (ifidRs),
        .IFID_Rt_i        (ifidRt),
        .Branch_i         (branch),
        .Jump_i           (jump),
        .EXMEM_MemRead_i  (exmemMemRead),
        .EXMEM_MemWrite_i (exmemMemWrite),
        .mem_ack_i        (memAck),
        .mem_req_o        (memReq),
        .PCWrite_o        (pcWrite),
        .IFIDWrite_o      (ifidWrite),
        .IDEXBubble_o     (idexBubble),
        .IFFlush_o        (ifFlush),
        .PipeStall_o      (pipeStall),
        .mem_timeout_o    (memTimeout),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt_o      (stallCnt),
`endif
        .state_o          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: inputs change 1 after the edge, outputs are sampled 3 after it.
    task automatic applyStimulus(input logic r, input logic exRd, input logic [4:0] exRt,
                                 input logic [4:0] idRs, input logic [4:0] idRt,
                                 input logic br, input logic jmp, input logic mRd,
                                 input logic mWr, input logic ack);
        @(posedge clk);
        #1;
        rst           = r;
        idexMemRead   = exRd;
        idexRt        = exRt;
        ifidRs        = idRs;
        ifidRt        = idRt;
        branch        = br;
        jump          = jmp;
        exmemMemRead  = mRd;
        exmemMemWrite = mWr;
        memAck        = ack;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCtrl(input string tag, input logic pc, input logic ifid,
                             input logic bub, input logic fl, input logic stl,
                             input logic req);
        checkOutput({tag, "/pcWrite"},   16'(pcWrite),    16'(pc));
        checkOutput({tag, "/ifidWrite"}, 16'(ifidWrite),  16'(ifid));
        checkOutput({tag, "/bubble"},    16'(idexBubble), 16'(bub));
        checkOutput({tag, "/flush"},     16'(ifFlush),    16'(fl));
        checkOutput({tag, "/stall"},     16'(pipeStall),  16'(stl));
        checkOutput({tag, "/memReq"},    16'(memReq),     16'(req));
    endtask

    initial begin
        rst = 1'b1; idexMemRead = 1'b0; idexRt = 5'd0; ifidRs = 5'd0; ifidRt = 5'd0;
        branch = 1'b0; jump = 1'b0; exmemMemRead = 1'b0; exmemMemWrite = 1'b0; memAck = 1'b0;

        // Reset: every control output low, even with a branch pending.
        applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
        checkCtrl("reset", 0, 0, 0, 0, 0, 0);
        checkOutput("reset/state", 16'(state), 16'd0);
        checkOutput("reset/timeout", 16'(memTimeout), 16'd0);

        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkCtrl("idle", 1, 1, 0, 0, 0, 0);

        // Load-use on Rs, on Rt, and the non-hazard variants.
        applyStimulus(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, 0);
        checkCtrl("loadUseRs", 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkCtrl("rtZero", 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 5'd5, 5'd3, 5'd5, 0, 0, 0, 0, 0);
        checkCtrl("loadUseRt", 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 5'd5, 5'd3, 5'd5, 0, 0, 0, 0, 0);
        checkCtrl("noLoad", 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 5'd9, 5'd3, 5'd5, 0, 0, 0, 0, 0);
        checkCtrl("noMatch", 1, 1, 0, 0, 0, 0);

        // Branch under a hazard is held off until the hazard clears.
        applyStimulus(0, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0, 0);
        checkCtrl("branchHazard", 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0, 0);
        checkCtrl("branchClear", 1, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
        checkCtrl("jump", 1, 1, 0, 1, 0, 0);

        // Load access acked on the third REQ cycle; stall dominates hazard and branch.
        applyStimulus(0, 1, 5'd8, 5'd8, 5'd0, 1, 0, 1, 0, 0);
        checkCtrl("accessRun", 0, 0, 0, 0, 1, 0);
        checkOutput("accessRun/state", 16'(state), 16'd0);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        checkCtrl("req1", 0, 0, 0, 0, 1, 1);
        checkOutput("req1/state", 16'(state), 16'd1);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        checkOutput("req2/state", 16'(state), 16'd1);
        checkOutput("req2/memReq", 16'(memReq), 16'd1);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
        checkOutput("req3/state", 16'(state), 16'd1);
        checkOutput("req3/memReq", 16'(memReq), 16'd1);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        checkCtrl("done", 1, 1, 0, 0, 0, 0);
        checkOutput("done/state", 16'(state), 16'd2);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkCtrl("backToRun", 1, 1, 0, 0, 0, 0);
        checkOutput("backToRun/state", 16'(state), 16'd0);

        // Spurious ack in RUN changes nothing.
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        checkOutput("spuriousAck/memReq", 16'(memReq), 16'd0);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("spuriousAck/state", 16'(state), 16'd0);

        // Store never acked: 15 REQ cycles then sticky ERR.
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        checkOutput("store/stall", 16'(pipeStall), 16'd1);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
            checkOutput($sformatf("timeoutReq%0d/state", i), 16'(state), 16'd1);
            checkOutput($sformatf("timeoutReq%0d/err", i), 16'(memTimeout), 16'd0);
        end
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        checkCtrl("err", 0, 0, 0, 0, 1, 0);
        checkOutput("err/state", 16'(state), 16'd3);
        checkOutput("err/timeout", 16'(memTimeout), 16'd1);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("errHeld/state", 16'(state), 16'd3);
        checkOutput("errHeld/timeout", 16'(memTimeout), 16'd1);
        applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkCtrl("errReset", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("afterErr/state", 16'(state), 16'd0);
        checkOutput("afterErr/timeout", 16'(memTimeout), 16'd0);

        // Reset in the second REQ cycle drops the request at once, no DONE follows.
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        checkOutput("midReq1/memReq", 16'(memReq), 16'd1);
        applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
        checkOutput("midReqRst/memReq", 16'(memReq), 16'd0);
        checkOutput("midReqRst/stall", 16'(pipeStall), 16'd0);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("midReqAfter/state", 16'(state), 16'd0);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("midReqAfter/stallCnt", stallCnt, 16'd0);
`endif
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("midReqNoDone/state", 16'(state), 16'd0);

        // Ack on the timeout cycle wins over the timeout.
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 14; i++)
            applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
        checkOutput("ackAtLimit/state", 16'(state), 16'd1);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("ackAtLimitDone/state", 16'(state), 16'd2);
        checkOutput("ackAtLimitDone/timeout", 16'(memTimeout), 16'd0);

`ifdef HAZARD_PERF_CNT_EN
        // Stall counter from reset into ERR, then saturation.
        applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        checkOutput("cntAfterRst", stallCnt, 16'd0);
        for (int i = 1; i <= 15; i++)
            applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("cntErrEntry/state", 16'(state), 16'd3);
        checkOutput("cntErrEntry", stallCnt, 16'd16);
        for (int i = 0; i < 65530; i++)
            applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("cntSaturated", stallCnt, 16'hFFFF);
        applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("cntCleared", stallCnt, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
